fifo_sync_ext: RTL
==================

# fifo_sync_ext

Parametrised successor to the team's single-clock FIFO. Adds a fill count, programmable almost-full/almost-empty thresholds, a read-valid strobe, synchronous flush and optional sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and is a drop-in for the existing FIFO: the base ports keep their names and timing, and the new ports are additive.

## Interface
- `DATA_WIDTH`, 32: word width in bits.
- `FIFO_DEPTH`, 8: number of entries; a power of two, at least 2.
- `AF_THRESH`, `FIFO_DEPTH-2`: `almost_full` asserts when `count >= AF_THRESH`.
- `AE_THRESH`, 2: `almost_empty` asserts when `count <= AE_THRESH`.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `cs` input 1: chip select; gates `wr_en`, `rd_en` and `flush`.
- `wr_en` input 1: write request.
- `rd_en` input 1: read request.
- `flush` input 1: discard all contents.
- `clr_err` input 1: clear the sticky error flags.
- `data_in` input DATA_WIDTH: write data.
- `data_out` output DATA_WIDTH: registered read data.
- `rd_valid` output 1: `data_out` was updated at this edge.
- `empty` output 1: `count == 0`.
- `full` output 1: `count == FIFO_DEPTH`.
- `almost_full` output 1: see `AF_THRESH`.
- `almost_empty` output 1: see `AE_THRESH`.
- `count` output $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` output 1: sticky; a write was attempted while full.
- `underflow` output 1: sticky; a read was attempted while empty.

## Operation
- Write accepted: `wr_acc = cs & wr_en & ~full & ~flush`.
- Read accepted: `rd_acc = cs & rd_en & ~empty & ~flush`.
- Acceptance uses the registered `full` and `empty` flags.
  - A write while full is dropped, even if a read happens in the same cycle.
  - A read while empty is rejected, even if a write happens in the same cycle.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally from `FIFO_DEPTH-1` to 0.
- `count` is a separate register: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- `empty`, `full`, `almost_full` and `almost_empty` are decoded from the registered `count` (combinational from a register, no extra latency).
- `flush` (qualified by `cs`) has priority over read and write:
  - pointers and `count` go to 0;
  - `data_out` holds its value;
  - `rd_valid` is 0;
  - error flags are unaffected.
- When `cs = 0`, all requests are ignored and no error is flagged.
- Reset values: `data_out` 0, `rd_valid` 0, `count` 0, `empty` 1, `full` 0, `almost_empty` 1, `almost_full` 0 (1 if `AF_THRESH == 0`), `overflow` 0, `underflow` 0. Memory contents are not reset.
- Reset asserted mid-operation: all state returns to the reset values at the next edge; an in-flight read produces no `rd_valid`.

## Timing
- Read latency is 1 cycle: for `rd_acc` sampled at edge N, `data_out` and `rd_valid = 1` appear after edge N. `rd_valid` is a 1-cycle pulse per accepted read.
- Write to read: a word written at edge N is readable from edge N+1, when `empty` deasserts.
- Flags and `count` update at the same edge as the accepted operation.
- Back-to-back reads and writes are accepted every cycle with no bubbles.

## Configuration
- `FIFO_SYNC_EXT_ERR_EN` defined:
  - `overflow` sets on `cs & wr_en & full`;
  - `underflow` sets on `cs & rd_en & empty`;
  - both clear on `clr_err` or reset; set takes priority over a same-cycle `clr_err`.
- Not defined: `overflow` and `underflow` are tied to 0, `clr_err` is ignored, and no error registers are synthesised. The ports remain in both builds.

## Structure
- Package `fifo_sync_pkg` holds:
  - `ADDR_W(depth)` / `CNT_W(depth)` width functions;
  - a compile-time check that the depth is a power of two and the thresholds lie in range.
- Sub-module `fifo_sync_ram`: `FIFO_DEPTH × DATA_WIDTH` array with one write port and one registered read port; it owns `data_out`.
- The top level holds pointers, count, flag decode, error logic and the `rd_valid` register.

## Test plan
All scenarios use DEPTH 8, WIDTH 32, AF 6, AE 2, with `FIFO_SYNC_EXT_ERR_EN` defined unless stated.
- Reset, then write 1, 10, 100 and read 4× → `data_out` 1, 10, 100 each with `rd_valid`. The 4th read gives no `rd_valid`, `underflow = 1`, and `data_out` holds 100.
- Write 2^0..2^8 (9 writes) → `full` after the 8th write, `count = 8`, `overflow = 1`. Then 8 reads return 1..128 in order and the 256 word is lost.
- Fill to 5, then a simultaneous write+read for 10 cycles → `count` stays 5 and the pointers wrap with FIFO order kept.
- Fill from 0 to 8 → `almost_empty` deasserts at `count = 3`, `almost_full` asserts at `count = 6`, and `full` asserts at 8.
- `flush` at `count = 4` together with `wr_en` and `rd_en` → `count = 0`, `empty = 1`, no `rd_valid`, `data_out` unchanged. `clr_err` then clears `overflow`/`underflow`.
- Build without the macro, repeat scenario 2 → `overflow` stays 0 and the data behaviour is identical.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared width helpers and parameter sanity check for the extended single-clock FIFO.
package fifo_sync_pkg;

    function automatic int unsigned ADDR_W(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned CNT_W(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int unsigned depth, input int unsigned af,
                                     input int unsigned ae);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) && (af <= depth) && (ae <= depth);
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// FIFO storage: one write port and one registered read port that drives data_out.
module fifo_sync_ram
    import fifo_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AW         = ADDR_W(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Storage is deliberately not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_ext.sv
// Extended single-clock FIFO: fill count, thresholds, rd_valid, flush.
// Sticky overflow/underflow flags are built only when FIFO_SYNC_EXT_ERR_EN is defined.
module fifo_sync_ext
    import fifo_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cs,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic                           flush,
    input  logic                           clr_err,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           rd_valid,
    output logic                           empty,
    output logic                           full,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [CNT_W(FIFO_DEPTH)-1:0]   count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int unsigned AW = ADDR_W(FIFO_DEPTH);
    localparam int unsigned CW = CNT_W(FIFO_DEPTH);

    if (!params_ok(FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("fifo_sync_ext: FIFO_DEPTH must be a power of two >= 2, thresholds <= depth");
    end

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          rd_valid_q;
    logic          wr_acc;
    logic          rd_acc;
    logic          flush_acc;

    // Acceptance looks at the registered flags, so a write at full is dropped even
    // when a read frees a slot in the same cycle.
    assign flush_acc = cs & flush;
    assign wr_acc    = cs & wr_en & ~full & ~flush;
    assign rd_acc    = cs & rd_en & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else if (flush_acc) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            rd_valid_q <= rd_acc;
        end
    end

    assign count        = count_q;
    assign rd_valid     = rd_valid_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));

    fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_acc),
        .wr_addr  (wr_ptr_q),
        .wr_data  (data_in),
        .rd_en    (rd_acc),
        .rd_addr  (rd_ptr_q),
        .data_out (data_out)
    );

`ifdef FIFO_SYNC_EXT_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // A new error event wins over a same-cycle clear so no event is ever lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (cs & wr_en & full) begin
                overflow_q <= 1'b1;
            end else if (clr_err) begin
                overflow_q <= 1'b0;
            end
            if (cs & rd_en & empty) begin
                underflow_q <= 1'b1;
            end else if (clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
